// File: rtl/miriscv_instr_mem_responder.sv
// Responder end of the miriscv instruction memory interface: fixed-latency,
// in-order fetch responses from a preloadable word array, plus error/count status.
module miriscv_instr_mem_responder #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned     LATENCY     = 1
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           instr_req_i,
  input  logic [XLEN-1:0]                instr_addr_i,
  output logic                           instr_rvalid_o,
  output logic [XLEN-1:0]                instr_rdata_o,
  input  logic                           load_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
  input  logic [XLEN-1:0]                load_wdata_i,
  input  logic                           err_clr_i,
  output logic                           err_o,
  output logic [XLEN-1:0]                err_addr_o,
  output logic [31:0]                    req_cnt_o
);

  localparam int unsigned     AW   = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] SPAN = XLEN'(4 * DEPTH_WORDS);
  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [XLEN-1:0] offset_s;
  logic [AW-1:0]   word_idx_s;
  logic            illegal_s;
  logic [XLEN-1:0] fetch_data_s;

  logic [LATENCY-1:0] valid_r;
  logic [XLEN-1:0]    data_r       [LATENCY];
  logic [LATENCY-1:0] stage_valid_s;
  logic [XLEN-1:0]    stage_data_s [LATENCY];

  logic            err_r;
  logic [XLEN-1:0] err_addr_r;
  logic [31:0]     req_cnt_r;

  // Address decode; addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  always_comb begin
    offset_s   = instr_addr_i - BASE_ADDR;
    word_idx_s = offset_s[AW+1:2];
    illegal_s  = (instr_addr_i[1:0] != 2'b00) || (offset_s >= SPAN);
    if (illegal_s) begin
      fetch_data_s = NOP;
    end else begin
      fetch_data_s = mem[word_idx_s];
    end
  end

  // Preload port; the read above sees the pre-write word on a shared edge.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  // Input of each pipeline stage: stage 0 takes the fresh fetch, others the previous stage.
  always_comb begin
    stage_valid_s = '0;
    stage_data_s  = '{default: '0};
    stage_valid_s[0] = instr_req_i;
    stage_data_s[0]  = fetch_data_s;
    for (int i = 1; i < int'(LATENCY); i++) begin
      stage_valid_s[i] = valid_r[i-1];
      stage_data_s[i]  = data_r[i-1];
    end
  end

  // Response pipeline; data only moves with a valid, so the last stage holds the last response.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      valid_r <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r <= stage_valid_s;
      for (int i = 0; i < int'(LATENCY); i++) begin
        if (stage_valid_s[i]) begin
          data_r[i] <= stage_data_s[i];
        end
      end
    end
  end

  // Sticky error capture (a new illegal fetch beats a same-edge clear) and request counter.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      err_r      <= 1'b0;
      err_addr_r <= '0;
      req_cnt_r  <= 32'd0;
    end else begin
      if (instr_req_i) begin
        req_cnt_r <= req_cnt_r + 32'd1;
      end
      if (instr_req_i && illegal_s && (!err_r || err_clr_i)) begin
        err_r      <= 1'b1;
        err_addr_r <= instr_addr_i;
      end else if (err_clr_i) begin
        err_r <= 1'b0;
      end
    end
  end

  assign instr_rvalid_o = valid_r[LATENCY-1];
  assign instr_rdata_o  = data_r[LATENCY-1];
  assign err_o          = err_r;
  assign err_addr_o     = err_addr_r;
  assign req_cnt_o      = req_cnt_r;

endmodule

// File: tb/tb_miriscv_instr_mem_responder.sv
// Bench for miriscv_instr_mem_responder: three instances (latency 1/2/3, the last
// at BASE 0x8000_0000) share one stimulus stream and are checked against a history model.
module tb_miriscv_instr_mem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        arstn;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [5:0]  laddr;
  logic [31:0] wdata;
  logic        clr;

  logic        rv  [3];
  logic [31:0] rd  [3];
  logic        err [3];
  logic [31:0] ea  [3];
  logic [31:0] cnt [3];

  always #5 clk = ~clk;

  miriscv_instr_mem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) dut1 (
    .clk_i(clk), .arstn_i(arstn), .instr_req_i(req), .instr_addr_i(addr),
    .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]), .load_we_i(we), .load_addr_i(laddr),
    .load_wdata_i(wdata), .err_clr_i(clr), .err_o(err[0]), .err_addr_o(ea[0]), .req_cnt_o(cnt[0]));

  miriscv_instr_mem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000), .LATENCY(2)) dut2 (
    .clk_i(clk), .arstn_i(arstn), .instr_req_i(req), .instr_addr_i(addr),
    .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]), .load_we_i(we), .load_addr_i(laddr),
    .load_wdata_i(wdata), .err_clr_i(clr), .err_o(err[1]), .err_addr_o(ea[1]), .req_cnt_o(cnt[1]));

  miriscv_instr_mem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) dut3 (
    .clk_i(clk), .arstn_i(arstn), .instr_req_i(req), .instr_addr_i(addr),
    .instr_rvalid_o(rv[2]), .instr_rdata_o(rd[2]), .load_we_i(we), .load_addr_i(laddr),
    .load_wdata_i(wdata), .err_clr_i(clr), .err_o(err[2]), .err_addr_o(ea[2]), .req_cnt_o(cnt[2]));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: record what each edge accepted, then the output after edge n is
  // whatever edge n-LAT+1 accepted, unless a reset edge came in between.
  int          lat_m  [3] = '{1, 2, 3};
  logic [31:0] base_m [3] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
  logic [31:0] mmem [DEPTH];
  bit          hv [3][1024];
  logic [31:0] hd [3][1024];
  int          edge_n   = 0;
  int          rst_edge = 0;
  bit          m_rv  [3];
  logic [31:0] m_rd  [3];
  bit          m_err [3];
  logic [31:0] m_ea  [3];
  logic [31:0] m_cnt [3];

  always @(posedge clk) begin : model
    logic [31:0] off;
    bit          bad;
    int          a;
    edge_n++;
    for (int j = 0; j < 3; j++) begin
      if (!arstn) begin
        rst_edge     = edge_n;
        hv[j][edge_n] = 1'b0;
        m_rv[j]  = 1'b0;
        m_rd[j]  = 32'd0;
        m_err[j] = 1'b0;
        m_ea[j]  = 32'd0;
        m_cnt[j] = 32'd0;
      end else begin
        hv[j][edge_n] = req;
        if (req) begin
          off = addr - base_m[j];
          bad = (addr % 4 != 0) || (off >= 32'(4 * DEPTH));
          hd[j][edge_n] = bad ? 32'h0000_0013 : mmem[off / 4];
          m_cnt[j] = m_cnt[j] + 32'd1;
          if (bad && (!m_err[j] || clr)) begin
            m_err[j] = 1'b1;
            m_ea[j]  = addr;
          end else if (clr) begin
            m_err[j] = 1'b0;
          end
        end else if (clr) begin
          m_err[j] = 1'b0;
        end
        a = edge_n - lat_m[j] + 1;
        if (a > rst_edge && hv[j][a]) begin
          m_rv[j] = 1'b1;
          m_rd[j] = hd[j][a];
        end else begin
          m_rv[j] = 1'b0;
        end
      end
    end
    if (we) mmem[laddr] = wdata;
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("rvalid[%0d]@%0d", j, edge_n), {31'd0, rv[j]}, {31'd0, m_rv[j]});
        chk($sformatf("rdata[%0d]@%0d", j, edge_n), rd[j], m_rd[j]);
        chk($sformatf("err[%0d]@%0d", j, edge_n), {31'd0, err[j]}, {31'd0, m_err[j]});
        chk($sformatf("err_addr[%0d]@%0d", j, edge_n), ea[j], m_ea[j]);
        chk($sformatf("req_cnt[%0d]@%0d", j, edge_n), cnt[j], m_cnt[j]);
      end
    end
  end

  task automatic cyc(input bit r, input logic [31:0] a, input bit w, input logic [5:0] la,
                     input logic [31:0] wd, input bit c);
    req = r; addr = a; we = w; laddr = la; wdata = wd; clr = c;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] a);
    cyc(1'b1, a, 1'b0, 6'd0, 32'd0, 1'b0);
  endtask

  task automatic load(input logic [5:0] la, input logic [31:0] wd);
    cyc(1'b0, 32'd0, 1'b1, la, wd, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = 32'd0;
    arstn = 1'b0;
    req = 1'b0; addr = 32'd0; we = 1'b0; laddr = 6'd0; wdata = 32'd0; clr = 1'b0;
    idle();
    idle();
    arstn  = 1'b1;
    chk_en = 1'b1;
    chk("reset_rvalid", {31'd0, rv[0]}, 32'd0);
    chk("reset_rdata", rd[0], 32'd0);
    chk("reset_err", {31'd0, err[0]}, 32'd0);
    chk("reset_cnt", cnt[2], 32'd0);

    // Latency 1 single fetch
    load(6'd0, 32'h0050_0093);
    fetch(32'h0);
    chk("t1_rvalid", {31'd0, rv[0]}, 32'd1);
    chk("t1_rdata", rd[0], 32'h0050_0093);
    chk("t1_cnt", cnt[0], 32'd1);
    idle();
    chk("t1_pulse", {31'd0, rv[0]}, 32'd0);

    // Latency 2 back-to-back
    load(6'd0, 32'h11);
    load(6'd1, 32'h22);
    load(6'd2, 32'h33);
    fetch(32'h0);
    chk("t2_lat", {31'd0, rv[1]}, 32'd0);
    fetch(32'h4);
    chk("t2_rv0", {31'd0, rv[1]}, 32'd1);
    chk("t2_rd0", rd[1], 32'h11);
    fetch(32'h8);
    chk("t2_rd1", rd[1], 32'h22);
    idle();
    chk("t2_rv2", {31'd0, rv[1]}, 32'd1);
    chk("t2_rd2", rd[1], 32'h33);
    idle();
    chk("t2_done", {31'd0, rv[1]}, 32'd0);
    chk("t2_hold", rd[1], 32'h33);
    chk("t2_cnt", cnt[1], 32'd4);

    // Illegal fetches and sticky error
    fetch(32'h6);
    chk("t3_nop", rd[0], 32'h0000_0013);
    chk("t3_err", {31'd0, err[0]}, 32'd1);
    chk("t3_ea", ea[0], 32'h6);
    fetch(32'h100);
    chk("t3_nop2", rd[0], 32'h0000_0013);
    chk("t3_ea_kept", ea[0], 32'h6);
    cyc(1'b0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1);
    chk("t3_clr", {31'd0, err[0]}, 32'd0);
    chk("t3_ea_ret", ea[0], 32'h6);
    cyc(1'b1, 32'h101, 1'b0, 6'd0, 32'd0, 1'b1);
    chk("t3_setwin", {31'd0, err[0]}, 32'd1);
    chk("t3_ea_new", ea[0], 32'h101);
    cyc(1'b1, 32'h104, 1'b0, 6'd0, 32'd0, 1'b1);
    chk("t3_ea_clrset", ea[0], 32'h104);
    cyc(1'b0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1);

    // Read-before-write on a shared edge
    load(6'd3, 32'hAAAA_AAAA);
    cyc(1'b1, 32'hC, 1'b1, 6'd3, 32'hBBBB_BBBB, 1'b0);
    chk("t4_old", rd[0], 32'hAAAA_AAAA);
    fetch(32'hC);
    chk("t4_new", rd[0], 32'hBBBB_BBBB);

    // Reset while a latency-3 response is in flight
    fetch(32'h8000_0008);
    idle();
    arstn = 1'b0;
    idle();
    arstn = 1'b1;
    idle();
    idle();
    chk("t5_no_rv", {31'd0, rv[2]}, 32'd0);
    chk("t5_cnt", cnt[2], 32'd0);
    chk("t5_err", {31'd0, err[2]}, 32'd0);
    fetch(32'h8000_0008);
    idle();
    idle();
    chk("t5_rv", {31'd0, rv[2]}, 32'd1);
    chk("t5_rd", rd[2], 32'h33);

    // Non-zero base address
    fetch(32'h8000_0004);
    idle();
    idle();
    chk("t6_rv", {31'd0, rv[2]}, 32'd1);
    chk("t6_rd", rd[2], 32'h22);
    fetch(32'h7FFF_FFFC);
    chk("t6_err", {31'd0, err[2]}, 32'd1);
    chk("t6_ea", ea[2], 32'h7FFF_FFFC);
    idle();
    idle();
    chk("t6_nop", rd[2], 32'h0000_0013);
    idle();
    idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
